bin_to_bcd_seq: RTL and testbench

//  Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.

---
 rtl/bin_to_bcd_seq_pkg.sv | 24 ++
 rtl/bin_to_bcd_seq_if.sv | 22 ++
 rtl/bin_to_bcd_seq_adj.sv | 13 +
 rtl/bin_to_bcd_seq.sv | 83 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned ADJ_THRESH = 5;
    localparam int unsigned ADJ_ADD    = 3;

    // Largest value representable in the given number of BCD digits.
    function automatic int unsigned bcd_max(input int unsigned digits);
        int unsigned m;
        m = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done request bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_adj.sv
// Combinational add-3 corrector for one BCD nibble, applied before each shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] value,
    output logic [NIBBLE_W-1:0] adjusted
);
    localparam logic [NIBBLE_W-1:0] Thresh = NIBBLE_W'(ADJ_THRESH);
    localparam logic [NIBBLE_W-1:0] AddVal = NIBBLE_W'(ADJ_ADD);

    // Carry out of the nibble is intentionally dropped.
    assign adjusted = (value >= Thresh) ? value + AddVal : value;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, registered result and
// saturation to all nines when the input exceeds the digit range.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input logic             clk,
    input logic             rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned BCD_W   = NIBBLE_W * DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned BCD_MAX = bcd_max(DIGITS);

    state_e             state_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pending_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               overflow_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .value    (scratch_q[g*NIBBLE_W +: NIBBLE_W]),
            .adjusted (scratch_adj[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            shreg_q       <= '0;
            scratch_q     <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bcd_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        shreg_q       <= bus.bin;
                        scratch_q     <= '0;
                        cnt_q         <= CNT_W'(BIN_W);
                        ovf_pending_q <= 32'(bus.bin) > BCD_MAX;
                        busy_q        <= 1'b1;
                        state_q       <= StShift;
                    end
                end
                StShift: begin
                    {scratch_q, shreg_q} <= {scratch_adj, shreg_q} << 1;
                    cnt_q                <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Wrapped scratch contents are discarded on overflow.
                    bcd_q      <= ovf_pending_q ? {DIGITS{4'h9}} : scratch_q;
                    overflow_q <= ovf_pending_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned LATENCY = BIN_W + 1;
    localparam int unsigned PERIOD  = BIN_W + 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          rem;
        if (v > 9999) return 16'h9999;
        r   = '0;
        rem = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done with a bound; returns number of ticks taken and max busy run.
    task automatic wait_done(input string tag, output int ticks, output int busy_cnt);
        ticks    = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && ticks < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            ticks++;
        end
        if (bus.done !== 1'b1) check({tag, "_timeout"}, 32'(bus.done), 32'd1);
    endtask

    // Single start pulse conversion with full result checking.
    task automatic convert(input string tag, input int v);
        int          t;
        int          b;
        logic [15:0] prev;
        prev      = bus.bcd;
        bus.bin   = 14'(v);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_hold"}, 32'(bus.bcd), 32'(prev));
        wait_done(tag, t, b);
        check({tag, "_lat"}, 32'(t), 32'(LATENCY));
        check({tag, "_busy"}, 32'(b), 32'(LATENCY));
        check({tag, "_bcd"}, 32'(bus.bcd), 32'(ref_bcd(v)));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(v > 9999));
        tick();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int t;
        int b;
        int dones;
        int v;
        tests     = 0;
        failed    = 0;
        bus.start = 1'b0;
        bus.bin   = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        convert("t1_1234", 1234);
        convert("t2_0", 0);
        convert("t2_9999", 9999);
        convert("t3_10000", 10000);
        convert("t3_16383", 16383);
        convert("t3_42", 42);

        // Start pulses during SHIFT/DONE must be ignored.
        bus.bin   = 14'd777;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dones     = 0;
        for (int i = 1; i <= 25; i++) begin
            if (bus.done === 1'b1) dones++;
            if (i >= 2 && i <= 13) begin
                bus.start = 1'b1;
                bus.bin   = 14'd5555;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        check("t4_dones", 32'(dones), 32'd1);
        check("t4_bcd", 32'(bus.bcd), 32'h0777);
        check("t4_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a conversion.
        bus.bin   = 14'd500;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_done", 32'(bus.done), 32'd0);
        check("t5_bcd", 32'(bus.bcd), 32'd0);
        check("t5_ovf", 32'(bus.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        check("t5_nodone", 32'(dones), 32'd0);
        convert("t5_321", 321);

        // Start held high: back-to-back conversions of 0..200.
        bus.bin   = 14'd0;
        bus.start = 1'b1;
        tick();
        for (int n = 0; n <= 200; n++) begin
            wait_done("t6", t, b);
            check("t6_gap", 32'(t), (n == 0) ? 32'(LATENCY) : 32'(PERIOD - 1));
            check("t6_bcd", 32'(bus.bcd), 32'(ref_bcd(n)));
            check("t6_ovf", 32'(bus.overflow), 32'd0);
            bus.bin = 14'(n + 1);
            tick();
        end
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // Random values with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, 16383));
            if (n % 4 == 0) v = int'($urandom_range(9990, 10010));
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
            convert("rand", v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
